// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial memory access controller.
//
// Executes one load or store per request over an 8-bit bus, one byte per
// cycle, little-endian (byte 0 at the latched address first). Loads are
// assembled into a 32-bit word and sign- or zero-extended into rdata when
// the access finishes.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous reset, active high
//   start     in   1  request strobe, sampled only while idle
//   mem_op    in   8  one-hot active-low {lb,lh,lw,lbu,lhu,sb,sh,sw}, bit7=lb
//   addr      in  32  byte address
//   wdata     in  32  store data
//   rdata     out 32  extended load result, held between loads
//   done      out  1  one-cycle completion pulse
//   err       out  1  one-cycle error pulse (invalid op / trapped misalign)
//   busy      out  1  high while an access is in progress
//   bus_addr  out 32  byte bus address
//   bus_dout  out  8  byte bus write data
//   bus_din   in   8  byte bus read data
//   bus_oe_n  out  1  read strobe, active low
//   bus_we_n  out  1  write strobe, active low
//
// Build option:
//   MEM_CTRL_MISALIGN_TRAP_EN  when defined, misaligned halfword/word
//                              requests finish immediately with err and
//                              no bus activity.

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_oe_n,
  output logic        bus_we_n
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FIN    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_op;      // latched op, active-high one-hot
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;     // load assembly buffer
  logic [31:0] r_rdata;
  logic [1:0]  r_cnt;
  logic        r_err;     // FIN reports err instead of done

  logic [7:0]  w_op_act;
  logic        w_op_none;
  logic        w_op_valid;
  logic        w_trap;
  logic        w_go;
  logic        w_fail;
  logic        w_store;
  logic        w_last;
  logic [31:0] w_buf_nxt;
  logic [31:0] w_ext;

  // Bytes minus one: word ops 3, halfword ops 1, byte ops 0.
  function automatic logic [1:0] f_len_m1(input logic [7:0] op);
    if (op[5] | op[0])
      return 2'd3;
    else if (op[6] | op[3] | op[1])
      return 2'd1;
    else
      return 2'd0;
  endfunction

  assign w_op_act   = ~mem_op;
  assign w_op_none  = (mem_op == 8'hFF);
  assign w_op_valid = $onehot(w_op_act);
  assign w_store    = |r_op[2:0];
  assign w_last     = (r_cnt == f_len_m1(r_op));

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  logic [1:0] w_in_len_m1;
  assign w_in_len_m1 = f_len_m1(w_op_act);
  assign w_trap = ((w_in_len_m1 == 2'd1) && addr[0]) ||
                  ((w_in_len_m1 == 2'd3) && (addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Buffer with the byte arriving this cycle merged into lane cnt, so the
  // final byte can be extended into rdata on the same edge it is captured.
  always_comb begin
    w_buf_nxt = r_buf;
    w_buf_nxt[{r_cnt, 3'b000} +: 8] = bus_din;
  end

  always_comb begin
    w_ext = w_buf_nxt;
    if (r_op[7])
      w_ext = {{24{w_buf_nxt[7]}}, w_buf_nxt[7:0]};
    else if (r_op[6])
      w_ext = {{16{w_buf_nxt[15]}}, w_buf_nxt[15:0]};
    else if (r_op[4])
      w_ext = {24'h000000, w_buf_nxt[7:0]};
    else if (r_op[3])
      w_ext = {16'h0000, w_buf_nxt[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_fail      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    bus_addr    = r_addr;
    bus_dout    = '0;
    bus_oe_n    = 1'b1;
    bus_we_n    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_op_valid && !w_trap) begin
            w_go        = 1'b1;
            w_state_nxt = S_ACCESS;
          end else if (!w_op_none) begin
            w_fail      = 1'b1;
            w_state_nxt = S_FIN;
          end
        end
      end
      S_ACCESS: begin
        busy     = 1'b1;
        bus_addr = r_addr + {30'd0, r_cnt};
        if (w_store) begin
          bus_we_n = 1'b0;
          bus_dout = r_wdata[{r_cnt, 3'b000} +: 8];
        end else begin
          bus_oe_n = 1'b0;
        end
        if (w_last)
          w_state_nxt = S_FIN;
      end
      S_FIN: begin
        busy        = 1'b1;
        done        = !r_err;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_op    <= w_op_act;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end else if (w_fail) begin
            r_err   <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 2'd1;
          if (!w_store) begin
            r_buf <= w_buf_nxt;
            if (w_last)
              r_rdata <= w_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: directed transactions followed by random ones,
// checked against a transaction-level reference model.

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_oe_n;
  logic        bus_we_n;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Model state: last load result and last accepted address.
  logic [31:0] m_rdata;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_op   (mem_op),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_oe_n (bus_oe_n),
    .bus_we_n (bus_we_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Op index 0..7 = lb, lh, lw, lbu, lhu, sb, sh, sw.
  function automatic int op_len(input int opi);
    case (opi)
      2, 7:    return 4;
      1, 4, 6: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit op_store(input int opi);
    return opi >= 5;
  endfunction

  function automatic bit op_trap(input int opi, input logic [31:0] a);
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    return (op_len(opi) == 2 && a[0]) || (op_len(opi) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Little-endian value of the first len bytes, extended arithmetically.
  function automatic logic [31:0] load_value(input int opi, input logic [31:0] raw);
    int len = op_len(opi);
    longint unsigned span = 64'd1 << (8 * len);
    longint unsigned v = {32'd0, raw} % span;
    if ((opi == 0 || opi == 1) && v >= span / 2)
      v = v - span + 64'h1_0000_0000;
    return v[31:0];
  endfunction

  // Full transaction from start through FIN, plus a start during FIN that
  // must be ignored. Called and returns at 1 time unit after a rising edge.
  task automatic run_op(input int opi, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] din, input string tag);
    int          len = op_len(opi);
    bit          st = op_store(opi);
    logic [7:0]  sel = 8'h80 >> opi;
    start  = 1'b1;
    mem_op = ~sel;
    addr   = a;
    wdata  = wd;
    @(posedge clk); #1;
    start  = 1'b0;
    mem_op = 8'hFF;
    addr   = $urandom;
    wdata  = $urandom;
    if (op_trap(opi, a)) begin
      chk({tag, ".trap_err"},   err, 1);
      chk({tag, ".trap_done"},  done, 0);
      chk({tag, ".trap_oe"},    bus_oe_n, 1);
      chk({tag, ".trap_we"},    bus_we_n, 1);
      chk({tag, ".trap_rdata"}, rdata, m_rdata);
      @(posedge clk); #1;
      chk({tag, ".trap_idle"},  busy, 0);
      chk({tag, ".trap_clr"},   err, 0);
      return;
    end
    m_addr = a;
    for (int i = 0; i < len; i++) begin
      bus_din = din[8*i +: 8];
      chk($sformatf("%s.busy%0d", tag, i), busy, 1);
      chk($sformatf("%s.done%0d", tag, i), done, 0);
      chk($sformatf("%s.addr%0d", tag, i), bus_addr, a + i);
      chk($sformatf("%s.oe%0d", tag, i),   bus_oe_n, st ? 1 : 0);
      chk($sformatf("%s.we%0d", tag, i),   bus_we_n, st ? 0 : 1);
      chk($sformatf("%s.dout%0d", tag, i), bus_dout, st ? wd[8*i +: 8] : 0);
      @(posedge clk); #1;
    end
    if (!st)
      m_rdata = load_value(opi, din);
    chk({tag, ".done"},     done, 1);
    chk({tag, ".err"},      err, 0);
    chk({tag, ".fin_busy"}, busy, 1);
    chk({tag, ".rdata"},    rdata, m_rdata);
    chk({tag, ".fin_oe"},   bus_oe_n, 1);
    chk({tag, ".fin_we"},   bus_we_n, 1);
    chk({tag, ".fin_addr"}, bus_addr, m_addr);
    chk({tag, ".fin_dout"}, bus_dout, 0);
    start  = 1'b1;
    mem_op = 8'hFE;
    addr   = $urandom;
    @(posedge clk); #1;
    start  = 1'b0;
    mem_op = 8'hFF;
    chk({tag, ".ign_busy"}, busy, 0);
    chk({tag, ".ign_done"}, done, 0);
    chk({tag, ".ign_we"},   bus_we_n, 1);
    chk({tag, ".ign_addr"}, bus_addr, m_addr);
    chk({tag, ".ign_rd"},   rdata, m_rdata);
  endtask

  task automatic run_bad(input logic [7:0] op, input string tag);
    start  = 1'b1;
    mem_op = op;
    addr   = $urandom;
    @(posedge clk); #1;
    start  = 1'b0;
    mem_op = 8'hFF;
    chk({tag, ".err"},   err, 1);
    chk({tag, ".done"},  done, 0);
    chk({tag, ".busy"},  busy, 1);
    chk({tag, ".oe"},    bus_oe_n, 1);
    chk({tag, ".we"},    bus_we_n, 1);
    chk({tag, ".addr"},  bus_addr, m_addr);
    chk({tag, ".rdata"}, rdata, m_rdata);
    @(posedge clk); #1;
    chk({tag, ".idle"},  busy, 0);
    chk({tag, ".clr"},   err, 0);
  endtask

  initial begin
    logic [7:0]  bad_op;
    logic [31:0] ra;
    rst     = 1'b1;
    start   = 1'b0;
    mem_op  = 8'hFF;
    addr    = '0;
    wdata   = '0;
    bus_din = '0;
    m_rdata = '0;
    m_addr  = '0;

    @(posedge clk); #1;
    chk("rst.busy",  busy, 0);
    chk("rst.done",  done, 0);
    chk("rst.err",   err, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.addr",  bus_addr, 0);
    chk("rst.dout",  bus_dout, 0);
    chk("rst.oe",    bus_oe_n, 1);
    chk("rst.we",    bus_we_n, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(7, 32'h0000_0100, 32'hA1B2_C3D4, 32'h0, "sw100");
    run_op(0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0080, "lb200");
    chk("lb200.const", rdata, 32'hFFFF_FF80);
    run_op(3, 32'h0000_0200, 32'h0, 32'h0000_0080, "lbu200");
    chk("lbu200.const", rdata, 32'h0000_0080);
    run_op(1, 32'h0000_0301, 32'h0, 32'h0000_9234, "lh301");
    run_op(2, 32'hFFFF_FFFE, 32'h0, 32'h5566_7788, "lwwrap");

    // Reset after the second byte of a word load.
    start  = 1'b1;
    mem_op = 8'hDF;
    addr   = 32'h0000_0400;
    @(posedge clk); #1;
    start   = 1'b0;
    mem_op  = 8'hFF;
    bus_din = 8'h11;
    @(posedge clk); #1;
    bus_din = 8'h22;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    m_rdata = '0;
    m_addr  = '0;
    chk("arst.busy",  busy, 0);
    chk("arst.oe",    bus_oe_n, 1);
    chk("arst.we",    bus_we_n, 1);
    chk("arst.done",  done, 0);
    chk("arst.addr",  bus_addr, 0);
    chk("arst.rdata", rdata, 0);
    @(posedge clk); #1;
    chk("arst.hold_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, "lwpost");

    run_bad(8'hF0, "badF0");
    start  = 1'b1;
    mem_op = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("none.busy", busy, 0);
    chk("none.done", done, 0);
    chk("none.err",  err, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        bad_op = 8'hFF;
        for (int k = 0; k < 32 && $countones(~bad_op) < 2; k++)
          bad_op = 8'($urandom);
        if ($countones(~bad_op) < 2)
          bad_op = 8'h00;
        run_bad(bad_op, $sformatf("rnd%0d", n));
      end else begin
        ra = $urandom;
        if ($urandom_range(0, 3) == 0)
          ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        run_op($urandom_range(0, 7), ra, $urandom, $urandom, $sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
